// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two burst requesters.
// Each grant issues LEN+1 consecutive reads; data returns one cycle later per requester.
module rom_read_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] len0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic              rvalid0_q, rvalid1_q;
    logic              winner;

    // With both requesting, the one that did not own the last burst wins.
    assign winner = (req0 && req1) ? ~last_owner_q : req1;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        base_d       = base_q;
        len_d        = len_q;
        beat_d       = beat_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    base_d       = winner ? addr1 : addr0;
                    len_d        = winner ? len1 : len0;
                    beat_d       = '0;
                    state_d      = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            beat_q       <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            rvalid0_q    <= rom_en && !owner_q;
            rvalid1_q    <= rom_en && owner_q;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
        len_q  <= len_d;
    end

    // Address wraps silently in ADDR_W bits; held at 0 when no read is issued.
    assign rom_en   = (state_q == S_BURST);
    assign rom_addr = rom_en ? (base_q + beat_q) : '0;
    assign gnt0     = rom_en && (beat_q == '0) && !owner_q;
    assign gnt1     = rom_en && (beat_q == '0) && owner_q;
    assign busy     = (state_q != S_IDLE);

    // Gating by rvalid keeps undefined ROM output off the data ports.
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rvalid0_q ? rom_data : '0;
    assign rdata1   = rvalid1_q ? rom_data : '0;

endmodule
